// File: rtl/rf_tx_iq_packer_if.sv
// Streaming sink, send-enable conduit and RF transmit pin bundle
// for the transmit I/Q packer.
interface rf_tx_iq_packer_if #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  asi_valid;
    logic [2*DATA_W-1:0]   asi_data;
    logic                  asi_ready;
    logic                  en_in;
    logic [DATA_W-1:0]     rftxdata;
    logic                  rftxen;
    logic                  rftxiqsel;
    logic                  stat_underrun;
    logic [LW-1:0]         stat_level;

    modport master (
        output asi_valid, asi_data, en_in,
        input  asi_ready, rftxdata, rftxen, rftxiqsel,
        input  stat_underrun, stat_level
    );

    modport slave (
        input  asi_valid, asi_data, en_in,
        output asi_ready, rftxdata, rftxen, rftxiqsel,
        output stat_underrun, stat_level
    );
endinterface

// File: rtl/rf_tx_iq_packer.sv
// Transmit packer: buffers 24-bit I/Q pairs in a FIFO and emits them
// as time-interleaved 12-bit words (I then Q) to the RF front end.
module rf_tx_iq_packer #(
    parameter int DATA_W      = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    rf_tx_iq_packer_if.slave     tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN_I,
        RUN_Q
    } state_e;

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]       head_idx;
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       head_lvl;
    logic [2*DATA_W-1:0] head;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                txen_q, txen_d;
    logic                iqsel_q, iqsel_d;
    logic                und_q, und_d;
    logic                push, pop;

    assign tx.asi_ready     = level_q < LW'(FIFO_DEPTH);
    assign tx.rftxdata      = data_q;
    assign tx.rftxen        = txen_q;
    assign tx.rftxiqsel     = iqsel_q;
    assign tx.stat_underrun = und_q;
    assign tx.stat_level    = level_q;

    assign push    = tx.asi_valid && tx.asi_ready;
    assign pop     = (state_q == RUN_Q);
    assign level_d = level_q + LW'(push) - LW'(pop);

    // Head seen by the next state; bypass the write when the FIFO
    // would otherwise be empty after this cycle's pop.
    assign head_idx = rd_ptr_q + PW'(pop);
    assign head_lvl = level_q - LW'(pop);
    assign head     = (head_lvl == '0) ? tx.asi_data : mem_q[head_idx];

    always_comb begin
        state_d = state_q;
        und_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx.en_in) state_d = PRIME;
            end
            PRIME: begin
                if (!tx.en_in)
                    state_d = IDLE;
                else if (level_q >= LW'(PRIME_LEVEL))
                    state_d = RUN_I;
            end
            RUN_I: begin
                state_d = RUN_Q;
            end
            RUN_Q: begin
                if (!tx.en_in) begin
                    state_d = IDLE;
                end else if (level_d == '0) begin
                    state_d = PRIME;
                    und_d   = 1'b1;
                end else begin
                    state_d = RUN_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txen_d  = 1'b0;
        iqsel_d = 1'b0;
        data_d  = '0;
        if (state_d == RUN_I) begin
            txen_d  = 1'b1;
            iqsel_d = 1'b1;
            data_d  = head[2*DATA_W-1:DATA_W];
        end else if (state_d == RUN_Q) begin
            txen_d  = 1'b1;
            data_d  = head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            txen_q   <= 1'b0;
            iqsel_q  <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            data_q   <= data_d;
            txen_q   <= txen_d;
            iqsel_q  <= iqsel_d;
            und_q    <= und_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Sample storage carries no reset; level and pointers qualify it.
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.asi_data;
    end
endmodule
